// File: rtl/uart_frame_rx_param_if.sv
// Byte-strobe input and frame-result outputs of the game-state link receiver.
// The slave modport is the receiver itself; the master modport is the UART/consumer side.
interface uart_frame_rx_param_if #(
   parameter int unsigned PAYLOAD_BYTES = 10
);
   logic                         rx_done;
   logic [7:0]                   current_rx;
   logic [8*PAYLOAD_BYTES-1:0]   payload_out;
   logic                         frame_valid;
   logic                         frame_err_csum;
   logic                         frame_err_timeout;
   logic [15:0]                  frame_count;
   logic                         busy;

   modport master (
      output rx_done, current_rx,
      input  payload_out, frame_valid, frame_err_csum, frame_err_timeout, frame_count, busy
   );

   modport slave (
      input  rx_done, current_rx,
      output payload_out, frame_valid, frame_err_csum, frame_err_timeout, frame_count, busy
   );
endinterface

// File: rtl/uart_frame_rx_param.sv
// Frame receiver for the inter-board game-state link: hunts a sync preamble, collects the
// payload into a shadow buffer, checks the optional checksum and commits whole frames at once.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HUNT    | counting consecutive SYNC_BYTE values, idle between frames
// ST_PAYLOAD | storing payload bytes into the shadow buffer
// ST_CHECK   | waiting for the checksum byte after a complete payload
module uart_frame_rx_param #(
   parameter int unsigned SYNC_LEN       = 4,
   parameter logic [7:0]  SYNC_BYTE      = 8'hFF,
   parameter int unsigned PAYLOAD_BYTES  = 10,
   parameter bit          CHECKSUM_EN    = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input logic                  clk,
   input logic                  rst,
   uart_frame_rx_param_if.slave bus
);

   localparam int unsigned SYNC_W = $clog2(SYNC_LEN + 1);
   localparam int unsigned IDX_W  = $clog2(PAYLOAD_BYTES + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned PW     = 8 * PAYLOAD_BYTES;

   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_CHECK   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SYNC_W-1:0] sync_q, sync_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        sum_q, sum_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [PW-1:0]     shadow_q, shadow_d;
   logic [PW-1:0]     payload_q, payload_d;
   logic [15:0]       count_q, count_d;
   logic              valid_q, valid_d;
   logic              err_csum_q, err_csum_d;
   logic              err_tmo_q, err_tmo_d;
   logic              busy_q, busy_d;
   logic [7:0]        csum_total;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_HUNT;
         sync_q     <= '0;
         idx_q      <= '0;
         sum_q      <= '0;
         tmo_q      <= '0;
         shadow_q   <= '0;
         payload_q  <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         err_csum_q <= 1'b0;
         err_tmo_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         idx_q      <= idx_d;
         sum_q      <= sum_d;
         tmo_q      <= tmo_d;
         shadow_q   <= shadow_d;
         payload_q  <= payload_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         err_csum_q <= err_csum_d;
         err_tmo_q  <= err_tmo_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sync_d     = sync_q;
      idx_d      = idx_q;
      sum_d      = sum_q;
      tmo_d      = tmo_q;
      shadow_d   = shadow_q;
      payload_d  = payload_q;
      count_d    = count_q;
      valid_d    = 1'b0;
      err_csum_d = 1'b0;
      err_tmo_d  = 1'b0;
      csum_total = sum_q + bus.current_rx;

      case (state_q)
         ST_HUNT: begin
            if (bus.rx_done) begin
               if (bus.current_rx == SYNC_BYTE) begin
                  if (sync_q == SYNC_LAST) begin
                     state_d = ST_PAYLOAD;
                     sync_d  = '0;
                     idx_d   = '0;
                     sum_d   = '0;
                     tmo_d   = '0;
                  end else begin
                     sync_d = sync_q + SYNC_W'(1);
                  end
               end else begin
                  sync_d = '0;
               end
            end
         end

         ST_PAYLOAD: begin
            if (bus.rx_done) begin
               for (int k = 0; k < int'(PAYLOAD_BYTES); k++) begin
                  if (idx_q == IDX_W'(k)) shadow_d[8*k +: 8] = bus.current_rx;
               end
               sum_d = csum_total;
               idx_d = idx_q + IDX_W'(1);
               tmo_d = '0;
               if (idx_q == IDX_LAST) begin
                  if (CHECKSUM_EN) begin
                     state_d = ST_CHECK;
                  end else begin
                     // shadow_d already holds the final byte, so the commit is whole-frame
                     payload_d = shadow_d;
                     valid_d   = 1'b1;
                     count_d   = count_q + 16'd1;
                     state_d   = ST_HUNT;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               err_tmo_d = 1'b1;
               state_d   = ST_HUNT;
               sync_d    = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ST_CHECK: begin
            if (bus.rx_done) begin
               if (csum_total == 8'h00) begin
                  payload_d = shadow_q;
                  valid_d   = 1'b1;
                  count_d   = count_q + 16'd1;
               end else begin
                  err_csum_d = 1'b1;
               end
               state_d = ST_HUNT;
               sync_d  = '0;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               err_tmo_d = 1'b1;
               state_d   = ST_HUNT;
               sync_d    = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            state_d = ST_HUNT;
            sync_d  = '0;
         end
      endcase

      busy_d = (state_d != ST_HUNT);
   end

   assign bus.payload_out       = payload_q;
   assign bus.frame_valid       = valid_q;
   assign bus.frame_err_csum    = err_csum_q;
   assign bus.frame_err_timeout = err_tmo_q;
   assign bus.frame_count       = count_q;
   assign bus.busy              = busy_q;

endmodule

// File: tb/tb_uart_frame_rx_param.sv
// Bench for uart_frame_rx_param: three instances (defaults, short timeout, 2-byte no-checksum)
// driven from one directed/randomised sequence and compared against a stream-level frame model.
module tb_uart_frame_rx_param;
   localparam int SL = 4;
   localparam int PB = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] cur = 8'h00;
   int         sel = 0;

   always #5 clk = ~clk;

   uart_frame_rx_param_if #(.PAYLOAD_BYTES(PB)) if_a ();
   uart_frame_rx_param_if #(.PAYLOAD_BYTES(PB)) if_b ();
   uart_frame_rx_param_if #(.PAYLOAD_BYTES(2))  if_c ();

   assign if_a.rx_done    = rx_done && (sel == 0);
   assign if_b.rx_done    = rx_done && (sel == 1);
   assign if_c.rx_done    = rx_done && (sel == 2);
   assign if_a.current_rx = cur;
   assign if_b.current_rx = cur;
   assign if_c.current_rx = cur;

   uart_frame_rx_param dut_a (.clk(clk), .rst(rst_n), .bus(if_a));
   uart_frame_rx_param #(.TIMEOUT_CYCLES(50)) dut_b (.clk(clk), .rst(rst_n), .bus(if_b));
   uart_frame_rx_param #(.SYNC_LEN(2), .PAYLOAD_BYTES(2), .CHECKSUM_EN(1'b0))
      dut_c (.clk(clk), .rst(rst_n), .bus(if_c));

   // pulse counters sampled mid-cycle
   int nv_a = 0, nc_a = 0, nt_a = 0, nv_b = 0, nt_b = 0, nv_c = 0, multi = 0;
   always @(negedge clk) begin
      if (if_a.frame_valid)       nv_a <= nv_a + 1;
      if (if_a.frame_err_csum)    nc_a <= nc_a + 1;
      if (if_a.frame_err_timeout) nt_a <= nt_a + 1;
      if (if_b.frame_valid)       nv_b <= nv_b + 1;
      if (if_b.frame_err_timeout) nt_b <= nt_b + 1;
      if (if_c.frame_valid)       nv_c <= nv_c + 1;
      if (int'(if_a.frame_valid) + int'(if_a.frame_err_csum) + int'(if_a.frame_err_timeout) > 1 ||
          int'(if_b.frame_valid) + int'(if_b.frame_err_csum) + int'(if_b.frame_err_timeout) > 1 ||
          int'(if_c.frame_valid) + int'(if_c.frame_err_csum) + int'(if_c.frame_err_timeout) > 1)
         multi <= multi + 1;
   end

   int npass = 0, ntotal = 0;
   logic [7:0] stream[$];

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rx_done = 1'b0;
      end
   endtask

   task automatic put(input logic [7:0] b, input int gapmax);
      @(negedge clk);
      rx_done = 1'b1;
      cur     = b;
      stream.push_back(b);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
   endtask

   // preamble + payload + checksum; cs_xor != 0 corrupts the checksum, stall idles after byte 0
   task automatic send_frame(input logic [79:0] pl, input logic [7:0] cs_xor,
                             input int gapmax, input int stall);
      logic [7:0] s;
      s = 8'h00;
      for (int k = 0; k < SL; k++) put(8'hFF, gapmax);
      for (int k = 0; k < PB; k++) begin
         s = s + pl[8*k +: 8];
         put(pl[8*k +: 8], gapmax);
         if (k == 0 && stall > 0) idle(stall);
      end
      put((8'h00 - s) ^ cs_xor, gapmax);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      rx_done = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
   endtask

   // Stream-level reference for the default configuration: find SL consecutive FFs,
   // then the next PB bytes are payload and the one after is the checksum.
   function automatic void model_run(output int nv, output int ne, output logic [79:0] last);
      int i, run;
      logic [7:0] s, t;
      nv = 0; ne = 0; last = '0; i = 0; run = 0;
      while (i < stream.size()) begin
         if (run == SL) begin
            if (i + PB + 1 > stream.size()) break;
            s = 8'h00;
            for (int k = 0; k < PB; k++) s = s + stream[i+k];
            t = s + stream[i+PB];
            if (t == 8'h00) begin
               nv++;
               for (int k = 0; k < PB; k++) last[8*k +: 8] = stream[i+k];
            end else begin
               ne++;
            end
            i += PB + 1;
            run = 0;
         end else begin
            run = (stream[i] == 8'hFF) ? run + 1 : 0;
            i++;
         end
      end
   endfunction

   initial begin
      logic [79:0] p1, p2, p3, pl, el;
      logic [7:0]  cx;
      int s_v, s_c, s_t, ev, ee, n;
      bit seen;
      p1 = 80'h0A090807060504030201;

      // reset state
      do_reset();
      check("rst_payload", if_a.payload_out, 80'h0);
      check("rst_count", if_a.frame_count, 80'h0);
      check("rst_busy", if_a.busy, 80'h0);
      check("rst_valid", if_a.frame_valid, 80'h0);

      // bad checksum C8
      s_v = nv_a; s_c = nc_a;
      send_frame(p1, 8'h01, 0, 0);
      idle(2);
      check("csum_err_pulse", nc_a - s_c, 80'd1);
      check("csum_no_valid", nv_a - s_v, 80'd0);
      check("csum_payload", if_a.payload_out, 80'h0);
      check("csum_count", if_a.frame_count, 80'h0);

      // good frame, checksum C9
      do_reset();
      s_v = nv_a; s_c = nc_a;
      send_frame(p1, 8'h00, 0, 0);
      idle(2);
      check("good_valid", nv_a - s_v, 80'd1);
      check("good_payload", if_a.payload_out, p1);
      check("good_count", if_a.frame_count, 80'd1);
      check("good_busy", if_a.busy, 80'h0);

      // broken preamble restarts the hunt
      do_reset();
      s_v = nv_a;
      put(8'hFF, 0); put(8'hFF, 0); put(8'h00, 0);
      send_frame(p1, 8'h00, 0, 0);
      idle(2);
      check("resync_valid", nv_a - s_v, 80'd1);
      check("resync_payload", if_a.payload_out, p1);

      // randomised frames with junk and gaps against the stream model
      do_reset();
      stream.delete();
      s_v = nv_a; s_c = nc_a;
      for (int seg = 0; seg < 8; seg++) begin
         n = $urandom_range(0, 4);
         for (int j = 0; j < n; j++) put(8'($urandom_range(0, 254)), 2);
         for (int k = 0; k < PB; k++) pl[8*k +: 8] = 8'($urandom_range(0, 255));
         cx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         send_frame(pl, cx, 2, 0);
         idle(2);
         model_run(ev, ee, el);
         check("rnd_valid", nv_a - s_v, ev);
         check("rnd_csum", nc_a - s_c, ee);
         check("rnd_count", if_a.frame_count, ev);
         check("rnd_payload", if_a.payload_out, el);
      end

      // reset mid-frame
      do_reset();
      send_frame(p1, 8'h00, 0, 0);
      for (int k = 0; k < SL; k++) put(8'hFF, 0);
      for (int k = 0; k < 5; k++) put(8'h30 + 8'(k), 0);
      @(negedge clk);
      rst_n = 1'b0; rx_done = 1'b0;
      s_v = nv_a; s_c = nc_a; s_t = nt_a;
      idle(3);
      check("midrst_pulses", (nv_a - s_v) + (nc_a - s_c) + (nt_a - s_t), 80'd0);
      check("midrst_payload", if_a.payload_out, 80'h0);
      check("midrst_count", if_a.frame_count, 80'h0);
      check("midrst_busy", if_a.busy, 80'h0);
      rst_n = 1'b1;
      idle(1);
      p2 = {$urandom, $urandom, $urandom} & 80'hFEFEFEFEFEFEFEFEFEFE;
      s_v = nv_a;
      send_frame(p2, 8'h00, 0, 0);
      idle(2);
      check("midrst_new_valid", nv_a - s_v, 80'd1);
      check("midrst_new_payload", if_a.payload_out, p2);
      check("midrst_new_count", if_a.frame_count, 80'd1);

      // timeout on the 50-cycle instance
      sel = 1;
      do_reset();
      s_v = nv_b; s_t = nt_b;
      for (int k = 0; k < SL; k++) put(8'hFF, 0);
      put(8'h01, 0); put(8'h02, 0); put(8'h03, 0);
      n = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk);
         rx_done = 1'b0;
         n++;
         if (n == 1) check("tmo_busy_before", if_b.busy, 80'd1);
         if (if_b.frame_err_timeout) seen = 1'b1;
      end
      // the first negedge observed already follows the sampling edge
      check("tmo_latency", n - 1, 80'd50);
      check("tmo_busy_after", if_b.busy, 80'h0);
      idle(2);
      check("tmo_pulses", nt_b - s_t, 80'd1);
      check("tmo_no_valid", nv_b - s_v, 80'd0);
      check("tmo_payload", if_b.payload_out, 80'h0);
      send_frame(p1, 8'h00, 0, 0);
      idle(2);
      check("tmo_next_valid", nv_b - s_v, 80'd1);
      check("tmo_next_payload", if_b.payload_out, p1);

      // byte arriving exactly on the expiry cycle wins; one cycle later it does not
      p3 = 80'h1A191817161514131211;
      s_v = nv_b; s_t = nt_b;
      send_frame(p3, 8'h00, 0, 49);
      idle(2);
      check("expiry_byte_wins_tmo", nt_b - s_t, 80'd0);
      check("expiry_byte_wins_valid", nv_b - s_v, 80'd1);
      check("expiry_byte_wins_payload", if_b.payload_out, p3);
      s_v = nv_b; s_t = nt_b;
      send_frame(80'h2A292827262524232221, 8'h00, 0, 50);
      idle(2);
      check("expiry_late_tmo", nt_b - s_t, 80'd1);
      check("expiry_late_valid", nv_b - s_v, 80'd0);
      check("expiry_late_payload", if_b.payload_out, p3);

      // back-to-back 2-byte frames without checksum
      sel = 2;
      do_reset();
      s_v = nv_c;
      for (int f = 0; f < 3; f++) begin
         put(8'hFF, 0); put(8'hFF, 0); put(8'hAA, 0); put(8'h55, 0);
      end
      idle(2);
      check("b2b_valid", nv_c - s_v, 80'd3);
      check("b2b_payload", if_c.payload_out, 80'h55AA);
      check("b2b_count", if_c.frame_count, 80'd3);

      check("pulse_exclusive", multi, 80'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule

// File: doc/uart_frame_rx_param.md
Name: uart_frame_rx_param

Overview:
Parametrised UART frame receiver and deserializer for the game-state link between the two boards. It consumes bytes from the UART receiver (rx_done/current_rx), hunts for a configurable sync preamble and collects a configurable-length payload. It validates an optional 8-bit checksum, enforces an inter-byte timeout, and commits each good frame atomically to a wide output register. Downstream game-state unpacking slices the fields from payload_out.

Parameters:
SYNC_LEN, 4, number of consecutive SYNC_BYTE values forming the preamble (1..8)
SYNC_BYTE, 8'hFF, preamble byte value
PAYLOAD_BYTES, 10, payload length in bytes (1..32)
CHECKSUM_EN, 1, 1 = one checksum byte follows the payload; 0 = no checksum byte
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between bytes inside a frame (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rx_done  input  1  one-cycle strobe: current_rx holds a new byte
current_rx  input  8  received byte, valid when rx_done=1
payload_out  output  8*PAYLOAD_BYTES  last good frame; byte k occupies bits [8k+7:8k], where byte 0 is the first byte after the preamble
frame_valid  output  1  one-cycle pulse when payload_out is updated
frame_err_csum  output  1  one-cycle pulse when a frame is dropped for checksum mismatch
frame_err_timeout  output  1  one-cycle pulse when a frame is aborted by timeout
frame_count  output  16  count of good frames, wraps 16'hFFFF->0
busy  output  1  1 in PAYLOAD or CHECK state

Behaviour:
- Reset: rst=0 asynchronously clears all state.
  - state=HUNT; sync counter, byte index, running sum and timeout counter = 0.
  - Shadow buffer = 0, payload_out = 0, frame_count = 0.
  - frame_valid, frame_err_csum, frame_err_timeout and busy = 0.
  - Reset mid-frame discards the partial frame; payload_out reverts to 0.
- All outputs are registered. Bytes are sampled only on cycles with rx_done=1.
- HUNT:
  - rx_done with current_rx==SYNC_BYTE increments the sync counter.
  - Any other byte clears the sync counter to 0.
  - When the counter reaches SYNC_LEN, go to PAYLOAD; clear byte index, sum and timeout counter.
- PAYLOAD:
  - Each rx_done writes the byte to shadow[index] and adds it to the sum (mod 256), then index++.
  - Bytes equal to SYNC_BYTE are ordinary payload; there is no re-sync inside a frame.
  - On the byte that makes index==PAYLOAD_BYTES:
    - CHECKSUM_EN=1: go to CHECK.
    - CHECKSUM_EN=0: commit and return to HUNT.
- CHECK:
  - The next rx_done carries the checksum C.
  - If (sum + C) mod 256 == 0: commit.
  - Otherwise pulse frame_err_csum; payload_out and frame_count are unchanged.
  - Either way, return to HUNT with the sync counter = 0.
- Commit:
  - payload_out <= shadow with the final byte merged in, all bytes in the same edge.
  - frame_valid=1 for exactly one cycle; frame_count increments.
  - Latency: frame_valid is high on the cycle after the clk edge that sampled the final rx_done.
- Timeout:
  - In PAYLOAD/CHECK the timeout counter increments every cycle without rx_done and clears on rx_done.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done: pulse frame_err_timeout and go to HUNT; payload_out is unchanged.
  - If rx_done coincides with the expiry cycle, the byte wins and no timeout occurs.
- payload_out is never partially updated; the consumer may sample it at any time.
- Back-to-back frames: the preamble may start on the byte immediately after the final payload/checksum byte.
- rx_done on consecutive cycles is legal; every strobe is consumed.
- Never more than one of frame_valid, frame_err_csum, frame_err_timeout is high in a cycle.

Test Plan:
1. Defaults. Send FF FF FF FF, payload 01..0A, checksum C9 (sum 0x37 + 0xC9 = 0x100) -> one frame_valid pulse; payload_out = 80'h0A09080706050403020 1 with byte 0 = 8'h01 in [7:0] and byte 9 = 8'h0A in [79:72]; frame_count=1.
2. Same frame with checksum C8 -> frame_err_csum pulse; no frame_valid; payload_out stays 0; frame_count=0.
3. Send FF FF 00 FF FF FF FF, then a valid frame -> the 00 restarts the hunt; exactly one frame_valid; the payload matches.
4. Preamble plus 3 payload bytes, then idle TIMEOUT_CYCLES (set to 50 for this test) -> frame_err_timeout pulses 50 cycles after the last rx_done; busy=0; a following valid frame is accepted.
5. CHECKSUM_EN=0, PAYLOAD_BYTES=2, SYNC_LEN=2. Send FF FF AA 55, three times back-to-back with rx_done every cycle -> three frame_valid pulses; payload_out=16'h55AA; frame_count=3.
6. Pull rst low after 5 payload bytes, release, then send a full valid frame -> no pulses during reset; all outputs 0 after reset; the new frame is committed with frame_count=1.
